// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame geometry, buffer
// addressing and the drain FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 104;  // 12 MHz / 115200
    localparam int UART_ADDR_W       = 9;    // 512-entry transmit buffer

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Read port of the transmit buffer RAM: the drain presents an address and
// the RAM returns the byte one clock later.
interface uart_tx_drain_if #(
    parameter int ADDR_W = uart_pkg::UART_ADDR_W
);
    import uart_pkg::*;

    logic [ADDR_W-1:0]         read_addr;
    logic [UART_DATA_BITS-1:0] read_data;

    modport master (output read_addr, input  read_data);
    modport slave  (input  read_addr, output read_data);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// period. A clear restarts the period so it lines up with a state change.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (i_clear || (cnt_reg == CNT_LAST)) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign o_tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_ram.sv
// Transmit buffer: simple dual-port RAM, one write port for the producer and
// a registered read port for the drain.
module uart_ram
    import uart_pkg::*;
#(
    parameter int ADDR_W = UART_ADDR_W
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [ADDR_W-1:0]         i_waddr,
    input  logic [UART_DATA_BITS-1:0] i_wdata,
    uart_tx_drain_if.slave            rd
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [UART_DATA_BITS-1:0] mem [0:DEPTH-1];

    // Read-before-write on a same-address collision; the drain never reads a
    // slot in the cycle it is written because FETCH adds a cycle of margin.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        rd.read_data <= mem[rd.read_addr];
    end

endmodule

// File: rtl/uart_tx_drain.sv
// Drains the transmit buffer: owns the tail pointer, fetches each byte through
// the RAM's registered read port and sends it as 8N1 UART, LSB first.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int ADDR_W       = UART_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_head,
    input  logic              i_flush,
    uart_tx_drain_if.master   rd,
    output logic [ADDR_W-1:0] o_tail,
    output logic              o_busy,
    output logic              o_tx
);

    localparam int              BIT_W    = $clog2(UART_DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_reg, state_next;
    logic [ADDR_W-1:0]         tail_reg, tail_next;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]          bit_reg, bit_next;
    logic                      tx_reg, tx_next;
    logic                      baud_tick;
    logic                      empty;

    assign empty = (tail_reg == i_head);

    // Every state change restarts the bit period, so each state that waits on
    // the timer gets a full CLKS_PER_BIT cycles.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (state_next != state_reg),
        .o_tick  (baud_tick)
    );

    always_comb begin
        state_next = state_reg;
        tail_next  = tail_reg;
        shift_next = shift_reg;
        bit_next   = bit_reg;
        tx_next    = tx_reg;

        unique case (state_reg)
            IDLE: begin
                if (i_flush) begin
                    tail_next = i_head;
                end else if (!empty) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                shift_next = rd.read_data;
                tail_next  = tail_reg + ADDR_W'(1);
                bit_next   = '0;
                tx_next    = 1'b0;
                state_next = START;
            end
            START: begin
                if (baud_tick) begin
                    tx_next    = shift_reg[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_next = shift_reg >> 1;
                    bit_next   = bit_reg + BIT_W'(1);
                    if (bit_reg == LAST_BIT) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        tx_next = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_next = empty ? IDLE : FETCH;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            tail_reg  <= '0;
            shift_reg <= '0;
            bit_reg   <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            tail_reg  <= tail_next;
            shift_reg <= shift_next;
            bit_reg   <= bit_next;
            tx_reg    <= tx_next;
        end
    end

    assign rd.read_addr = tail_reg;
    assign o_tail       = tail_reg;
    assign o_busy       = (state_reg != IDLE);
    assign o_tx         = tx_reg;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with the buffer RAM: reset, single byte,
// burst, pointer wrap, flush and same-slot write race.
module tb_uart_tx_drain;

    localparam int CPB = 4;
    localparam int AW  = 9;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [AW-1:0] head  = '0;
    logic          flush = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [7:0]    wdata = '0;
    logic [AW-1:0] tail;
    logic          busy;
    logic          tx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_drain_if #(.ADDR_W(AW)) rd_bus ();

    uart_ram #(.ADDR_W(AW)) u_ram (
        .i_clk   (clk),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .rd      (rd_bus)
    );

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_head  (head),
        .i_flush (flush),
        .rd      (rd_bus),
        .o_tail  (tail),
        .o_busy  (busy),
        .o_tx    (tx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ram_write(input logic [AW-1:0] a, input logic [7:0] d);
        waddr = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    // Waits (bounded) for the start bit; exp_lat < 0 skips the latency check.
    task automatic wait_low(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " start"}, 32'(tx), 32'd0);
        if (exp_lat >= 0) chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    endtask

    // Called on the first cycle of the start bit; checks every cycle of the
    // 10-bit frame and optionally pulses i_flush at cycle flush_at.
    task automatic frame(input string tag, input logic [7:0] b, input int flush_at);
        logic e;
        int   idx;
        for (int c = 0; c < 10 * CPB; c++) begin
            idx = c / CPB;
            if (idx == 0)      e = 1'b0;
            else if (idx == 9) e = 1'b1;
            else               e = b[idx-1];
            chk($sformatf("%s bit%0d", tag, idx), 32'(tx), 32'(e));
            flush = (c == flush_at);
            tick();
        end
        flush = 1'b0;
        $display("frame %s byte %02h checked, tail %0d", tag, b, tail);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset tail", 32'(tail), 32'd0);
        chk("reset read_addr", 32'(rd_bus.read_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Single byte: two high cycles (FETCH, LOAD) after head moves, then start
        ram_write(9'd0, 8'hA5);
        head = 9'd1;
        wait_low("single", 3);
        chk("single tail", 32'(tail), 32'd1);
        frame("single", 8'hA5, -1);
        chk("single idle busy", 32'(busy), 32'd0);
        chk("single idle tx", 32'(tx), 32'd1);

        // Asynchronous reset in the middle of a data bit
        ram_write(9'd1, 8'h00);
        head = 9'd2;
        wait_low("rstframe", 3);
        repeat (2 * CPB + 2) tick();
        chk("pre-reset tx", 32'(tx), 32'd0);
        chk("pre-reset busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midreset tx", 32'(tx), 32'd1);
        chk("midreset tail", 32'(tail), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        head = 9'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post-reset busy", 32'(busy), 32'd0);
        chk("post-reset tx", 32'(tx), 32'd1);

        // Burst: frames separated only by the FETCH and LOAD cycles
        ram_write(9'd0, 8'h00);
        ram_write(9'd1, 8'hFF);
        ram_write(9'd2, 8'h55);
        head = 9'd3;
        wait_low("burst0", 3);
        frame("burst0", 8'h00, -1);
        wait_low("burst1", 2);
        frame("burst1", 8'hFF, -1);
        wait_low("burst2", 2);
        frame("burst2", 8'h55, -1);
        chk("burst tail", 32'(tail), 32'd3);
        chk("burst busy", 32'(busy), 32'd0);

        // Pointer wrap 510 -> 511 -> 0 -> 1
        head  = 9'd510;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("wrap preset tail", 32'(tail), 32'd510);
        chk("wrap preset busy", 32'(busy), 32'd0);
        ram_write(9'd510, 8'h11);
        ram_write(9'd511, 8'h22);
        ram_write(9'd0, 8'h33);
        head = 9'd1;
        wait_low("wrap0", 3);
        chk("wrap0 tail", 32'(tail), 32'd511);
        frame("wrap0", 8'h11, -1);
        wait_low("wrap1", 2);
        chk("wrap1 tail", 32'(tail), 32'd0);
        frame("wrap1", 8'h22, -1);
        wait_low("wrap2", 2);
        chk("wrap2 tail", 32'(tail), 32'd1);
        frame("wrap2", 8'h33, -1);
        chk("wrap busy", 32'(busy), 32'd0);

        // Flush in IDLE wins over the pending bytes
        head  = 9'd5;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush tail", 32'(tail), 32'd5);
        chk("flush busy", 32'(busy), 32'd0);
        repeat (8) begin
            tick();
            chk("flush no frame busy", 32'(busy), 32'd0);
            chk("flush no frame tx", 32'(tx), 32'd1);
        end

        // Flush during DATA is ignored: all three queued bytes still go out
        ram_write(9'd5, 8'hC3);
        ram_write(9'd6, 8'hAA);
        ram_write(9'd7, 8'h0F);
        head = 9'd8;
        wait_low("fdata0", 3);
        frame("fdata0", 8'hC3, 12);
        wait_low("fdata1", 2);
        chk("fdata1 tail", 32'(tail), 32'd7);
        frame("fdata1", 8'hAA, -1);
        wait_low("fdata2", 2);
        frame("fdata2", 8'h0F, -1);
        chk("fdata tail", 32'(tail), 32'd8);
        chk("fdata busy", 32'(busy), 32'd0);

        // Same-slot race: slot written on the edge that also reveals it
        ram_write(9'd8, 8'h99);
        waddr = 9'd8;
        wdata = 8'h5A;
        we    = 1'b1;
        head  = 9'd9;
        tick();
        we = 1'b0;
        wait_low("race", 2);
        frame("race", 8'h5A, -1);
        chk("race tail", 32'(tail), 32'd9);
        chk("race busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
